// File: rtl/gnrc_codec_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gnrc_codec_pkg: shared mode encoding and payload-width helper for codec blocks.
// Rev 1.0
// ----------------------------------------------------------------------------
package gnrc_codec_pkg;

    typedef enum logic {
        LZC_LEAD  = 1'b0,
        LZC_TRAIL = 1'b1
    } lzc_mode_e;

    // Post-shift payload is packed as {empty, cnt, norm}.
    function automatic int lzc_post_w(input int width);
        return 1 + $clog2(width) + width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnrc_pipe_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gnrc_pipe_stage: single-entry valid/ready register slice, loads when empty or draining.
// Rev 1.0
// ----------------------------------------------------------------------------
module gnrc_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (ready_o) begin
                valid_q <= valid_i;
            end
            if (valid_i && ready_o) begin
                data_q <= data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnrc_lzc_norm_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gnrc_lzc_norm_pipe: pipelined leading/trailing-zero counter with normalising shift.
// GNRC_LZC_NORM_PERF_EN adds output-transfer counters. Rev 1.0
// ----------------------------------------------------------------------------
module gnrc_lzc_norm_pipe
    import gnrc_codec_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  STAGES = 2,
    localparam int CNT_W  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] in_i,
    input  logic             mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [WIDTH-1:0] norm_o,
    output logic             empty_o
`ifdef GNRC_LZC_NORM_PERF_EN
    ,
    output logic [31:0]      perf_xfer_o,
    output logic [31:0]      perf_empty_o
`endif
);

    localparam int PW = lzc_post_w(WIDTH);

    logic [CNT_W-1:0] cnt_c;
    logic             empty_c;
    logic [PW-1:0]    out_data;

    function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] d,
                                                    input logic m,
                                                    input logic [CNT_W-1:0] c);
        return (lzc_mode_e'(m) == LZC_TRAIL) ? (d >> c) : (d << c);
    endfunction

    // Scan order makes the last hit the relevant set bit, so no found flag is needed.
    always_comb begin
        cnt_c   = '0;
        empty_c = ~|in_i;
        if (lzc_mode_e'(mode_i) == LZC_TRAIL) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_c = CNT_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_c = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_single
            gnrc_pipe_stage #(.DATA_W(PW)) u_stage0 (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .valid_i (valid_i),
                .ready_o (ready_o),
                .data_i  ({empty_c, cnt_c, norm_shift(in_i, mode_i, cnt_c)}),
                .valid_o (valid_o),
                .ready_i (ready_i),
                .data_o  (out_data)
            );
        end else begin : g_multi
            logic [PW:0]   s0_q;
            logic          s0_valid;
            logic [PW-1:0] cd [1:STAGES];
            logic [STAGES:1] cv;
            logic [STAGES:1] cr;

            // Stage 0 holds {mode, empty, cnt, raw operand}; the shift follows it.
            gnrc_pipe_stage #(.DATA_W(PW + 1)) u_stage0 (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .valid_i (valid_i),
                .ready_o (ready_o),
                .data_i  ({mode_i, empty_c, cnt_c, in_i}),
                .valid_o (s0_valid),
                .ready_i (cr[1]),
                .data_o  (s0_q)
            );

            assign cv[1]      = s0_valid;
            assign cd[1]      = {s0_q[PW-1:WIDTH],
                                 norm_shift(s0_q[WIDTH-1:0], s0_q[PW], s0_q[WIDTH +: CNT_W])};
            assign cr[STAGES] = ready_i;
            assign valid_o    = cv[STAGES];
            assign out_data   = cd[STAGES];

            for (genvar k = 1; k < STAGES; k++) begin : g_stage
                gnrc_pipe_stage #(.DATA_W(PW)) u_stage (
                    .clk_i   (clk_i),
                    .rst_ni  (rst_ni),
                    .valid_i (cv[k]),
                    .ready_o (cr[k]),
                    .data_i  (cd[k]),
                    .valid_o (cv[k+1]),
                    .ready_i (cr[k+1]),
                    .data_o  (cd[k+1])
                );
            end
        end
    endgenerate

    assign {empty_o, cnt_o, norm_o} = out_data;

`ifdef GNRC_LZC_NORM_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_xfer_o  <= '0;
            perf_empty_o <= '0;
        end else if (valid_o && ready_i) begin
            perf_xfer_o <= perf_xfer_o + 32'd1;
            if (empty_o) begin
                perf_empty_o <= perf_empty_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gnrc_lzc_norm_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gnrc_lzc_norm_pipe: randomized and directed bench with a behavioural scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gnrc_lzc_norm_pipe;

`ifdef GNRC_LZC_NORM_PERF_EN
    localparam int W = 13;
    localparam int S = 3;
`else
    localparam int W = 16;
    localparam int S = 2;
`endif
    localparam int CW = $clog2(W);

    typedef logic [W+CW:0] res_t;   // {empty, cnt, norm}

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  in_i = '0;
    logic          mode_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [CW-1:0] cnt_o;
    logic [W-1:0]  norm_o;
    logic          empty_o;
`ifdef GNRC_LZC_NORM_PERF_EN
    logic [31:0]   perf_xfer_o;
    logic [31:0]   perf_empty_o;
`endif

    int   tests = 0;
    int   fails = 0;
    int   out_cnt = 0;
    res_t exp_q[$];

    gnrc_lzc_norm_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .in_i    (in_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .cnt_o   (cnt_o),
        .norm_o  (norm_o),
        .empty_o (empty_o)
`ifdef GNRC_LZC_NORM_PERF_EN
        ,
        .perf_xfer_o  (perf_xfer_o),
        .perf_empty_o (perf_empty_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference: walk the operand one bit at a time until the set bit reaches the edge.
    function automatic res_t model(input logic [W-1:0] d, input logic m);
        logic [W-1:0] n = d;
        int c = 0;
        if (d != '0) begin
            if (m == 1'b0) begin
                while (n[W-1] == 1'b0) begin n = n << 1; c++; end
            end else begin
                while (n[0] == 1'b0) begin n = n >> 1; c++; end
            end
        end
        return {(d == '0), CW'(c), n};
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r = W'($urandom);
        int k = $urandom_range(0, W - 1);
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'(1) << k;
            2:       return r >> k;
            default: return r << k;
        endcase
    endfunction

    // Scoreboard and stall-stability checker, sampled on the falling edge.
    logic stall_prev = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t act, exp;
        act = {empty_o, cnt_o, norm_o};
        if (!rst_ni) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                if (!valid_o || act !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b %h required v=1 %h", valid_o, act, held);
                end
            end
            if (valid_o && ready_i) begin
                tests++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got %h required no output", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        fails++;
                        $display("FAIL scoreboard: got %h required %h", act, exp);
                    end
                end
            end
            stall_prev = valid_o && !ready_i;
            held = act;
            if (valid_i && ready_o) exp_q.push_back(model(in_i, mode_i));
        end
    end

    task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic m);
        int t = 0;
        logic acc;
        valid_i = 1'b1;
        in_i    = d;
        mode_i  = m;
        do begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        check("push_timeout", acc, 64'(t), 64'd50);
    endtask

    // Single item through an empty pipe: literal result, model pin and latency.
    task automatic check_one(input string name, input logic [W-1:0] d, input logic m,
                             input logic [CW-1:0] ec, input logic [W-1:0] en, input logic ee);
        res_t want = {ee, ec, en};
        res_t r    = model(d, m);
        int   n    = 1;
        check({name, "_model"}, r === want, 64'(r), 64'(want));
        ready_i = 1'b1;
        valid_i = 1'b1;
        in_i    = d;
        mode_i  = m;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        while (!valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n == S, 64'(n), 64'(S));
        check(name, valid_o && ({empty_o, cnt_o, norm_o} === want),
              64'({empty_o, cnt_o, norm_o}), 64'(want));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_low;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o == 1'b0, 64'(valid_o), 64'd0);
        check("rst_outputs", {empty_o, cnt_o, norm_o} == '0, 64'({empty_o, cnt_o, norm_o}), 64'd0);
        check("rst_ready_o", ready_o == 1'b1, 64'(ready_o), 64'd1);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

`ifdef GNRC_LZC_NORM_PERF_EN
        check_one("lz_0001", 13'h0001, 1'b0, 4'd12, 13'h1000, 1'b0);
        check_one("lz_0600", 13'h0600, 1'b0, 4'd2,  13'h1800, 1'b0);
        check_one("tz_0600", 13'h0600, 1'b1, 4'd9,  13'h0003, 1'b0);
        check_one("tz_zero", 13'h0000, 1'b1, 4'd0,  13'h0000, 1'b1);
        check_one("lz_zero", 13'h0000, 1'b0, 4'd0,  13'h0000, 1'b1);
        check_one("tz_ones", 13'h1FFF, 1'b1, 4'd0,  13'h1FFF, 1'b0);
`else
        check_one("lz_0314", 16'h0314, 1'b0, 4'd6,  16'hC500, 1'b0);
        check_one("tz_0314", 16'h0314, 1'b1, 4'd2,  16'h00C5, 1'b0);
        check_one("tz_0500", 16'h0500, 1'b1, 4'd8,  16'h0005, 1'b0);
        check_one("lz_0500", 16'h0500, 1'b0, 4'd5,  16'hA000, 1'b0);
        check_one("lz_zero", 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1);
        check_one("tz_zero", 16'h0000, 1'b1, 4'd0,  16'h0000, 1'b1);
        check_one("lz_ffff", 16'hFFFF, 1'b0, 4'd0,  16'hFFFF, 1'b0);
        check_one("tz_ffff", 16'hFFFF, 1'b1, 4'd0,  16'hFFFF, 1'b0);
        check_one("lz_0001", 16'h0001, 1'b0, 4'd15, 16'h8000, 1'b0);
`endif

        // Backpressure: four back-to-back items, three-cycle stall on first output.
        out_cnt = 0;
        saw_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(rand_op(), i[0]);
                valid_i = 1'b0;
            end
            begin
                int t = 0;
                while (!valid_o && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!ready_o) saw_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                ready_i = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_ready_drop", saw_low, 64'(saw_low), 64'd1);
        check("bp_out_count", out_cnt == 4, 64'(out_cnt), 64'd4);
        check("bp_queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

        // Reset with two items held in the pipe.
        ready_i = 1'b0;
        push(rand_op() | W'(1), 1'b0);
        push(rand_op() | W'(1), 1'b1);
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
        check("midrst_valid_o", valid_o == 1'b0, 64'(valid_o), 64'd0);
        check("midrst_ready_o", ready_o == 1'b1, 64'(ready_o), 64'd1);
        ready_i = 1'b1;
        out_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_stale", out_cnt == 0, 64'(out_cnt), 64'd0);
`ifdef GNRC_LZC_NORM_PERF_EN
        check_one("post_rst", 13'h0001, 1'b0, 4'd12, 13'h1000, 1'b0);
`else
        check_one("post_rst", 16'h0314, 1'b0, 4'd6, 16'hC500, 1'b0);
`endif

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            in_i    = rand_op();
            mode_i  = 1'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rand_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

`ifdef GNRC_LZC_NORM_PERF_EN
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
        check("perf_rst", perf_xfer_o == 0 && perf_empty_o == 0,
              {perf_xfer_o, perf_empty_o}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            push((i == 2 || i == 5 || i == 8) ? W'(0) : (rand_op() | W'(1)), i[0]);
        end
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("perf_xfer", perf_xfer_o == 32'd10, 64'(perf_xfer_o), 64'd10);
        check("perf_empty", perf_empty_o == 32'd3, 64'(perf_empty_o), 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gnrc_lzc_norm_pipe.md
Name: gnrc_lzc_norm_pipe

Overview:
- Pipelined leading/trailing-zero counter with an integrated normalising shifter and valid/ready handshake on both sides.
- Successor to the combinational LZC: width and pipeline depth are parametrised, and count direction is selectable per transaction at run time.
- Also returns the normalised operand. Used ahead of FP normalisation, priority arbitration and address-decode paths that need a registered, back-pressurable count.

Parameters:
- WIDTH, 16, operand width; legal range is 2 or more.
- STAGES, 2, register stages from input to output; legal range 1..4.
- CNT_W, $clog2(WIDTH), count width; derived localparam, not overridable.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- valid_i  input  1  input transaction valid
- ready_o  output  1  block can accept input this cycle
- in_i  input  WIDTH  operand
- mode_i  input  1  0 = leading-zero count, 1 = trailing-zero count
- valid_o  output  1  output transaction valid
- ready_i  input  1  downstream accepts output
- cnt_o  output  CNT_W  zero count
- norm_o  output  WIDTH  normalised operand
- empty_o  output  1  operand was all zeros

Behaviour:
- Reset and transfer:
  - Reset is sampled on the clk_i edge while rst_ni is 0.
  - On reset, all stage valid bits clear and all data registers clear, so valid_o=0, cnt_o=0, norm_o=0, empty_o=0.
  - A transfer occurs on a rising edge with valid&&ready on that side.
- Pipeline:
  - There are STAGES stages, each holding a valid bit plus payload.
  - A stage loads when it is empty or when its contents move on in the same cycle.
  - ready_o = !v[0] || (next stage of stage 0 accepts); this is a bubble-collapsing chain with no combinational path from ready_i to valid_o.
  - ready_i-to-ready_o combinational path is allowed.
- Latency and throughput:
  - With ready_i held at 1, an input accepted at edge t appears with valid_o=1 after edge t+STAGES-1. Latency is STAGES cycles and throughput is 1/cycle.
- Output stability: while valid_o && !ready_i, all outputs hold stable and the pipeline stalls. The last stage never drops or overwrites data. Order is strictly FIFO.
- Stage split:
  - Stage 0 registers the count and empty flag, computed combinationally from in_i and mode_i, plus the raw operand and mode.
  - The shift happens between stage 0 and stage 1 when STAGES ≥ 2. When STAGES = 1 the shift is done before stage 0.
  - Further stages are pure delay.
- Arithmetic:
  - LZ mode: cnt = number of zeros above the highest set bit; norm = in << cnt, so the MSB is 1.
  - TZ mode: cnt = number of zeros below the lowest set bit; norm = in >> cnt, so the LSB is 1.
  - Shifts are logical and zero-fill; no set bit is ever shifted out.
- All-zero operand: empty_o=1, cnt_o=0, norm_o=0, in both modes.
- Non-power-of-two WIDTH: the maximum count is WIDTH-1 and fits CNT_W.
- mode_i is sampled only on input transfer and travels with the data; changing mode_i while the pipeline is occupied does not affect in-flight items.
- Reset mid-operation: in-flight items are discarded. valid_o=0 and ready_o=1 from the edge after reset is released.

Optional Feature:
- Macro: GNRC_LZC_NORM_PERF_EN.
- When defined, adds outputs perf_xfer_o[31:0] and perf_empty_o[31:0]:
  - perf_xfer_o counts output transfers (valid_o&&ready_i).
  - perf_empty_o counts output transfers with empty_o=1.
  - Both wrap modulo 2^32 and are cleared by rst_ni.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package gnrc_codec_pkg holds:
  - typedef enum logic {LZC_LEAD=1'b0, LZC_TRAIL=1'b1} lzc_mode_e;
  - the stage payload struct parametrised by the WIDTH/CNT_W localparam pattern, or per-instance packed fields if a struct cannot be parametrised.
- One natural sub-module: gnrc_pipe_stage.
  - Generic valid/ready single-entry register with parametrised payload width; it encodes the load/stall rule once.
  - Instantiated STAGES times via generate.
- The count and shift logic stays inline.

Test Plan:
- Defaults, ready_i=1, LZ, in_i=16'h0314 → after 2 cycles valid_o=1, cnt_o=6, norm_o=16'hC500, empty_o=0.
- TZ: in_i=16'h0314 → cnt_o=2, norm_o=16'h00C5. in_i=16'h0500 → cnt_o=8, norm_o=16'h0005. In LZ, 16'h0500 → cnt_o=5, norm_o=16'hA000.
- Boundaries: in_i=16'h0000 → empty_o=1, cnt_o=0, norm_o=0 in both modes. in_i=16'hFFFF → cnt_o=0, norm_o=16'hFFFF. LZ in_i=16'h0001 → cnt_o=15, norm_o=16'h8000.
- Backpressure:
  - Stimulus: 4 back-to-back inputs with alternating mode, ready_i=0 for 3 cycles after the first output appears.
  - ready_o drops once 2 items are held.
  - Outputs stay stable while stalled.
  - All 4 results emerge in order with the correct per-item mode and no loss or duplicates.
- Reset mid-flight: 2 items in the pipe, rst_ni=0 for 1 cycle → valid_o=0 and no stale item appears. The next input returns its correct result after 2 cycles.
- With GNRC_LZC_NORM_PERF_EN, WIDTH=13, STAGES=3, 10 transfers of which 3 are zero operands → perf_xfer_o=10, perf_empty_o=3, latency is 3 cycles, and LZ of 13'h0001 gives cnt_o=12.
